dither_line_sched: RTL
======================

// Module: dither_line_sched
//
// PURPOSE
//   Sequencer for the dither line-buffer bank. Tracks the incoming greyscale pixel
//   stream (bw_*), rotates the line-buffer role select (line_mux) at every row end,
//   and holds off output until enough rows are buffered (priming). It latches the
//   dither mode only at frame start, so the buffer roles never change mid-frame.
//   It also produces the delayed (a_*) coordinates consumed by the dither kernels.
//
// PARAMETERS
//   FRAME_WIDTH   320  pixels per row; hcount range 0..FRAME_WIDTH-1
//   FRAME_HEIGHT  180  rows per frame; vcount range 0..FRAME_HEIGHT-1
//   PRIME_LINES   2    completed rows required before a_valid may assert
//
// PORTS
//   clk_in           in   1   system clock
//   rst_in           in   1   synchronous, active-high reset
//   bw_hcount        in   11  column of incoming pixel
//   bw_vcount        in   10  row of incoming pixel
//   bw_pixel_valid   in   1   incoming pixel qualifier
//   dither_settings  in   3   [2]=fake dither, [1]=atkinson (else floyd-steinberg), [0]=freeze
//   line_mux         out  2   line-buffer role select; 0..2 (FS/fake), 0..3 (atkinson)
//   mode_atk         out  1   latched mode: 1 = atkinson (4 buffers), 0 = 3 buffers
//   mode_fake        out  1   latched mode: fake dither
//   a_hcount         out  11  kernel column = bw_hcount-1, saturating at 0
//   a_vcount         out  10  kernel row = bw_vcount-PRIME_LINES, saturating at 0
//   a_valid          out  1   kernel pixel valid
//   line_done        out  1   1-cycle pulse: the row end accepted on the previous cycle
//   settings_pending out  1   decoded dither_settings differ from the latched mode
//
// BEHAVIOUR
//   - Reset: state=IDLE; line_mux=0; mode_atk=0; mode_fake=0; a_hcount=0; a_vcount=0;
//     a_valid=0; line_done=0; settings_pending=0; prime counter=0.
//   - Accepted pixel: bw_pixel_valid && hcount<FRAME_WIDTH && vcount<FRAME_HEIGHT.
//     Out-of-range coordinates are ignored entirely.
//   - Frame start: accepted pixel at (0,0). Row end: accepted pixel with hcount=FRAME_WIDTH-1.
//     In fake mode, row end is hcount=FRAME_WIDTH-1 regardless of valid.
//   - NL = mode_atk ? 4 : 3. Rotation: line_mux <= (line_mux==NL-1) ? 0 : line_mux+1.
//   - FSM states:
//     IDLE:   no rotation; a_valid=0. On frame start: latch modes, line_mux<=0, prime<=0.
//             Then go to FROZEN if settings[0]=1, else to PRIME.
//     PRIME:  rotate at each row end; prime++ at each row end.
//             On the row end that makes prime==PRIME_LINES, go to RUN.
//     RUN:    rotate at each row end. Row end with vcount=FRAME_HEIGHT-1 -> IDLE.
//     FROZEN: line_mux and modes held; a_valid=0; buffers not advanced.
//             Each frame start re-samples settings[0]: 0 -> latch modes, line_mux<=0, -> PRIME.
//   - A frame start seen in PRIME or RUN (truncated frame) restarts as if from IDLE,
//     on the same cycle.
//   - Outputs are registered, latency 1 cycle from bw_*.
//     a_valid = accepted && state==RUN on that cycle.
//     a_hcount and a_vcount update only on accepted pixels.
//   - Simultaneous events: a row end that is also the final row takes the rotation first,
//     then the transition to IDLE. Its a_valid still asserts.
//   - line_mux is never >= NL. A mode change from atkinson to 3-buffer while line_mux=3
//     is impossible, because modes change only together with line_mux<=0.
//   - settings_pending is combinational from the inputs and the latched state,
//     registered by 1 cycle. It is 0 in IDLE.
//   - Reset mid-frame: every output returns to its reset value next cycle.
//     The block resumes only at the next frame start.
//
// TESTING
//   1. FS frame, 320x180 with valid every cycle. line_mux goes 0,1,2,0,...
//      First a_valid is 1 cycle after (0,2), with a_hcount=0 and a_vcount=0.
//   2. settings=3'b010 at frame start: mode_atk=1 and line_mux cycles 0..3.
//      Toggle settings to 3'b000 mid-frame -> mode_atk stays 1 and settings_pending=1
//      until the next (0,0).
//   3. Freeze: settings[0]=1 at frame start -> a_valid stays 0 for the whole frame
//      and line_mux stays constant. Clear it -> next (0,0) re-enters PRIME with line_mux=0.
//   4. Valid gaps: toggle valid 50% at random; the pixel at h=319 arrives with valid=0.
//      No rotation occurs until the valid h=319 pixel. Fake mode rotates on h=319
//      even with valid=0.
//   5. Assert rst_in at (150,90) -> all outputs 0 next cycle. Pixels before the next (0,0)
//      give a_valid=0 and no line_mux change.
//   6. Inject (0,0) at row 50 of a running frame -> line_mux=0 and PRIME again;
//      a_valid returns at row 2. Inject hcount=400 -> it is ignored.

Source files
------------

// File: rtl/dither_line_sched_if.sv
// Pixel-stream and kernel-side signals of the dither line scheduler.
// The slave modport faces the scheduler and the master modport faces the stream source and kernels.
interface dither_line_sched_if;
  logic [10:0] bw_hcount;
  logic [9:0]  bw_vcount;
  logic        bw_pixel_valid;
  logic [2:0]  dither_settings;
  logic [1:0]  line_mux;
  logic        mode_atk;
  logic        mode_fake;
  logic [10:0] a_hcount;
  logic [9:0]  a_vcount;
  logic        a_valid;
  logic        line_done;
  logic        settings_pending;

  modport master (
    output bw_hcount, bw_vcount, bw_pixel_valid, dither_settings,
    input  line_mux, mode_atk, mode_fake, a_hcount, a_vcount, a_valid,
           line_done, settings_pending
  );

  modport slave (
    input  bw_hcount, bw_vcount, bw_pixel_valid, dither_settings,
    output line_mux, mode_atk, mode_fake, a_hcount, a_vcount, a_valid,
           line_done, settings_pending
  );
endinterface

// File: rtl/dither_line_sched.sv
// Line-buffer sequencer for the dither bank: rotates buffer roles at row ends, primes
// the first rows of a frame and produces the delayed kernel coordinates.
module dither_line_sched #(
  parameter int unsigned FRAME_WIDTH  = 320,
  parameter int unsigned FRAME_HEIGHT = 180,
  parameter int unsigned PRIME_LINES  = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  dither_line_sched_if.slave bus
);
  localparam int unsigned PW = (PRIME_LINES < 2) ? 1 : $clog2(PRIME_LINES + 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FROZEN} state_e;

  state_e          state_q, state_d;
  logic [1:0]      line_mux_q, line_mux_d;
  logic            mode_atk_q, mode_atk_d;
  logic            mode_fake_q, mode_fake_d;
  logic [10:0]     a_hcount_q, a_hcount_d;
  logic [9:0]      a_vcount_q, a_vcount_d;
  logic            a_valid_q, a_valid_d;
  logic            line_done_q, line_done_d;
  logic            pending_q, pending_d;
  logic [PW-1:0]   prime_q, prime_d;

  logic            h_in_range, v_in_range, accepted, frame_start;
  logic            last_col, last_row, row_end;
  logic            set_atk, set_fake, set_freeze;
  logic [1:0]      mux_max, mux_next;
  logic [PW-1:0]   prime_inc;

  always_comb begin
    h_in_range  = bus.bw_hcount < 11'(FRAME_WIDTH);
    v_in_range  = bus.bw_vcount < 10'(FRAME_HEIGHT);
    accepted    = bus.bw_pixel_valid && h_in_range && v_in_range;
    frame_start = accepted && (bus.bw_hcount == '0) && (bus.bw_vcount == '0);
    last_col    = bus.bw_hcount == 11'(FRAME_WIDTH - 1);
    last_row    = bus.bw_vcount == 10'(FRAME_HEIGHT - 1);
    // Fake dither advances on the row-end column even when the pixel is not qualified.
    row_end     = last_col && v_in_range && (bus.bw_pixel_valid || mode_fake_q);

    set_fake    = bus.dither_settings[2];
    set_atk     = bus.dither_settings[1] & ~bus.dither_settings[2];
    set_freeze  = bus.dither_settings[0];

    mux_max     = mode_atk_q ? 2'd3 : 2'd2;
    mux_next    = (line_mux_q == mux_max) ? '0 : line_mux_q + 2'd1;
    prime_inc   = prime_q + PW'(1);

    state_d     = state_q;
    line_mux_d  = line_mux_q;
    mode_atk_d  = mode_atk_q;
    mode_fake_d = mode_fake_q;
    prime_d     = prime_q;
    a_hcount_d  = a_hcount_q;
    a_vcount_d  = a_vcount_q;
    a_valid_d   = 1'b0;
    line_done_d = 1'b0;

    if (accepted) begin
      a_hcount_d = (bus.bw_hcount == '0) ? '0 : bus.bw_hcount - 11'd1;
      a_vcount_d = (bus.bw_vcount < 10'(PRIME_LINES)) ? '0 : bus.bw_vcount - 10'(PRIME_LINES);
    end

    // Frame start restarts from any state; a frozen block stays frozen while freeze is set.
    if (frame_start && !(state_q == FROZEN && set_freeze)) begin
      mode_atk_d  = set_atk;
      mode_fake_d = set_fake;
      line_mux_d  = '0;
      prime_d     = '0;
      state_d     = set_freeze ? FROZEN : PRIME;
    end else begin
      unique case (state_q)
        PRIME: begin
          if (row_end) begin
            line_mux_d  = mux_next;
            line_done_d = 1'b1;
            prime_d     = prime_inc;
            if (prime_inc == PW'(PRIME_LINES)) state_d = RUN;
          end
        end
        RUN: begin
          a_valid_d = accepted;
          if (row_end) begin
            line_mux_d  = mux_next;
            line_done_d = 1'b1;
            if (last_row) state_d = IDLE;
          end
        end
        default: ;
      endcase
    end

    pending_d = (state_q != IDLE) &&
                ({set_fake, set_atk} != {mode_fake_q, mode_atk_q});
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      line_mux_q  <= '0;
      mode_atk_q  <= 1'b0;
      mode_fake_q <= 1'b0;
      prime_q     <= '0;
      a_hcount_q  <= '0;
      a_vcount_q  <= '0;
      a_valid_q   <= 1'b0;
      line_done_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_mux_q  <= line_mux_d;
      mode_atk_q  <= mode_atk_d;
      mode_fake_q <= mode_fake_d;
      prime_q     <= prime_d;
      a_hcount_q  <= a_hcount_d;
      a_vcount_q  <= a_vcount_d;
      a_valid_q   <= a_valid_d;
      line_done_q <= line_done_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.line_mux         = line_mux_q;
  assign bus.mode_atk         = mode_atk_q;
  assign bus.mode_fake        = mode_fake_q;
  assign bus.a_hcount         = a_hcount_q;
  assign bus.a_vcount         = a_vcount_q;
  assign bus.a_valid          = a_valid_q;
  assign bus.line_done        = line_done_q;
  assign bus.settings_pending = pending_q;
endmodule
